// File: rtl/operand_collector_if.sv
// Put-stream and bundle-output signals of the operand collector.
// The slave modport is the collector's view; master is the view of its surrounding logic.
interface operand_collector_if #(
  parameter int W     = 8,
  parameter int NSLOT = 3,
  parameter int CW    = $clog2(NSLOT + 1)
);
  logic                 put_valid;
  logic [W-1:0]         put_data;
  logic [CW-1:0]        need;
  logic                 flush;
  logic                 put_ready;
  logic                 bundle_valid;
  logic                 bundle_ready;
  logic [NSLOT*W-1:0]   slot_data;
  logic [NSLOT-1:0]     slot_valid;
  logic [CW-1:0]        count;
  logic                 err_need;

  modport slave (
    input  put_valid, put_data, need, flush, bundle_ready,
    output put_ready, bundle_valid, slot_data, slot_valid, count, err_need
  );

  modport master (
    output put_valid, put_data, need, flush, bundle_ready,
    input  put_ready, bundle_valid, slot_data, slot_valid, count, err_need
  );
endinterface

// File: rtl/operand_collector.sv
// Collects up to NSLOT operand words into a fill buffer, then hands the finished
// bundle to a double-buffered output register guarded by a valid/ready handshake.
module operand_collector #(
  parameter int W     = 8,
  parameter int NSLOT = 3,
  parameter int CW    = $clog2(NSLOT + 1)
) (
  input logic                  clk,
  input logic                  reset,
  operand_collector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FILL, FULL} fillState_t;

  fillState_t           stateQ, stateNext;
  logic [CW-1:0]        countQ, countNext;
  logic [CW-1:0]        needQ, needNext;
  logic [W-1:0]         fillQ [NSLOT];
  logic [W-1:0]         fillNext [NSLOT];
  logic [NSLOT*W-1:0]   outDataQ, outDataNext;
  logic [NSLOT-1:0]     outMaskQ, outMaskNext;
  logic                 outValidQ, outValidNext;
  logic                 errNeedQ, errNeedNext;

  logic                 putReady, accept, xferOk, completes, loadOut, needBad;
  logic [CW-1:0]        needClamp, effNeed;
  logic [W-1:0]         mergedData [NSLOT];
  logic [NSLOT-1:0]     loadMask;
  logic [NSLOT*W-1:0]   loadData;

  assign needBad   = (bus.need == '0) || (bus.need > CW'(NSLOT));
  assign needClamp = needBad ? CW'(NSLOT) : bus.need;
  assign putReady  = !reset && !bus.flush && (stateQ != FULL);
  assign accept    = bus.put_valid && putReady;
  assign xferOk    = !outValidQ || bus.bundle_ready;
  // The bundle length is only known from the incoming need on the first word.
  assign effNeed   = (stateQ == IDLE) ? needClamp : needQ;
  assign completes = accept && ((countQ + CW'(1)) == effNeed);
  assign loadOut   = !bus.flush && xferOk && (completes || (stateQ == FULL));

  // Output image: fill contents plus the word arriving this cycle, unused slots zeroed.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : gSlot
      assign mergedData[gi] = (accept && (countQ == CW'(gi))) ? bus.put_data : fillQ[gi];
      assign loadMask[gi]   = CW'(gi) < effNeed;
      assign loadData[gi*W +: W] = loadMask[gi] ? mergedData[gi] : '0;
    end
  endgenerate

  always_comb begin
    stateNext    = stateQ;
    countNext    = countQ;
    needNext     = needQ;
    fillNext     = fillQ;
    errNeedNext  = 1'b0;
    outValidNext = outValidQ && !bus.bundle_ready;
    outDataNext  = outDataQ;
    outMaskNext  = outMaskQ;

    if (loadOut) begin
      outValidNext = 1'b1;
      outDataNext  = loadData;
      outMaskNext  = loadMask;
    end

    if (bus.flush) begin
      stateNext = IDLE;
      countNext = '0;
      for (int i = 0; i < NSLOT; i++) fillNext[i] = '0;
    end else begin
      case (stateQ)
        IDLE, FILL: begin
          if (accept) begin
            fillNext[countQ] = bus.put_data;
            if (stateQ == IDLE) begin
              needNext    = needClamp;
              errNeedNext = needBad;
            end
            if (completes && xferOk) begin
              stateNext = IDLE;
              countNext = '0;
            end else begin
              stateNext = completes ? FULL : FILL;
              countNext = countQ + CW'(1);
            end
          end
        end
        FULL: begin
          if (xferOk) begin
            stateNext = IDLE;
            countNext = '0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ    <= IDLE;
      countQ    <= '0;
      needQ     <= '0;
      outDataQ  <= '0;
      outMaskQ  <= '0;
      outValidQ <= 1'b0;
      errNeedQ  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) fillQ[i] <= '0;
    end else begin
      stateQ    <= stateNext;
      countQ    <= countNext;
      needQ     <= needNext;
      outDataQ  <= outDataNext;
      outMaskQ  <= outMaskNext;
      outValidQ <= outValidNext;
      errNeedQ  <= errNeedNext;
      for (int i = 0; i < NSLOT; i++) fillQ[i] <= fillNext[i];
    end
  end

  assign bus.put_ready    = putReady;
  assign bus.bundle_valid = outValidQ;
  assign bus.slot_data    = outDataQ;
  assign bus.slot_valid   = outMaskQ;
  assign bus.count        = countQ;
  assign bus.err_need     = errNeedQ;

endmodule

// File: tb/tb_operand_collector.sv
// Directed and randomized checks of operand_collector against a queue-based model
// of the collect/emit behaviour.
module tb_operand_collector;
  localparam int W     = 8;
  localparam int NSLOT = 3;
  localparam int CW    = $clog2(NSLOT + 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_collector_if #(.W(W), .NSLOT(NSLOT)) bus();

  operand_collector #(.W(W), .NSLOT(NSLOT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: words waiting in the fill buffer, plus the held output bundle.
  logic [W-1:0] fillQ [$];
  int           needQ;
  bit           outValid;
  int           outN;
  logic [W-1:0] outData [NSLOT];
  bit           expErr;
  bit           expPr;
  logic         obsPr;

  task automatic model_reset();
    fillQ.delete();
    needQ    = 0;
    outValid = 0;
    outN     = 0;
    expErr   = 0;
    for (int i = 0; i < NSLOT; i++) outData[i] = '0;
  endtask

  function automatic logic [NSLOT*W-1:0] exp_data();
    logic [NSLOT*W-1:0] d = '0;
    for (int i = 0; i < NSLOT; i++) d[i*W +: W] = outData[i];
    return d;
  endfunction

  function automatic logic [NSLOT-1:0] exp_mask();
    logic [NSLOT-1:0] m = '0;
    for (int i = 0; i < outN; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Drive one cycle of inputs, advance the model, and return just after the edge.
  task automatic cycle(input bit pv, input logic [W-1:0] pd, input logic [CW-1:0] nd,
                       input bit fl, input bit br);
    bit acc, tr, cons, bad;
    bus.put_valid    = pv;
    bus.put_data     = pd;
    bus.need         = nd;
    bus.flush        = fl;
    bus.bundle_ready = br;
    #1;
    obsPr = bus.put_ready;
    expPr = !fl && !(fillQ.size() != 0 && fillQ.size() == needQ);
    acc   = pv && expPr;
    tr    = !outValid || br;
    cons  = outValid && br;
    expErr = 0;
    if (fl) fillQ.delete();
    else if (acc) begin
      if (fillQ.size() == 0) begin
        bad    = (nd == 0) || (int'(nd) > NSLOT);
        needQ  = bad ? NSLOT : int'(nd);
        expErr = bad;
      end
      fillQ.push_back(pd);
    end
    if (!fl && fillQ.size() != 0 && fillQ.size() == needQ && tr) begin
      outN = needQ;
      for (int i = 0; i < NSLOT; i++) outData[i] = (i < needQ) ? fillQ[i] : '0;
      outValid = 1;
      fillQ.delete();
    end else if (cons) outValid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit br);
    cycle(1'b0, '0, '0, 1'b0, br);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.put_valid = 0; bus.put_data = '0; bus.need = '0; bus.flush = 0; bus.bundle_ready = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    nChecks++;
    if (bus.put_ready !== 1'b0) begin nFails++; $display("FAIL reset_put_ready got %b exp 0", bus.put_ready); end
    nChecks++;
    if ({bus.bundle_valid, bus.slot_valid, bus.count, bus.err_need, bus.slot_data} !== '0) begin
      nFails++;
      $display("FAIL reset_outputs got bv=%b sv=%b cnt=%0d err=%b data=%h exp all 0",
               bus.bundle_valid, bus.slot_valid, bus.count, bus.err_need, bus.slot_data);
    end
    reset = 1'b0;
    #1;
    nChecks++;
    if (bus.put_ready !== 1'b1) begin nFails++; $display("FAIL reset_release_ready got %b exp 1", bus.put_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    cycle(1, 8'h11, 2'd3, 0, 1);
    nChecks++;
    if (bus.count !== 2'd1 || bus.bundle_valid !== 1'b0) begin
      nFails++; $display("FAIL basic_first got cnt=%0d bv=%b exp cnt=1 bv=0", bus.count, bus.bundle_valid);
    end
    cycle(1, 8'h22, 2'd0, 0, 1);
    cycle(1, 8'h33, 2'd0, 0, 1);
    nChecks++;
    if (bus.bundle_valid !== 1'b1 || bus.slot_data !== 24'h332211 || bus.slot_valid !== 3'b111 || bus.count !== 2'd0) begin
      nFails++;
      $display("FAIL basic_bundle got bv=%b data=%h sv=%b cnt=%0d exp bv=1 data=332211 sv=111 cnt=0",
               bus.bundle_valid, bus.slot_data, bus.slot_valid, bus.count);
    end
    idle(1);
    nChecks++;
    if (bus.bundle_valid !== 1'b0) begin nFails++; $display("FAIL basic_consumed got bv=%b exp 0", bus.bundle_valid); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'hA0 + 8'(i), 2'd1, 0, 1);
      nChecks++;
      if (obsPr !== 1'b1 || bus.bundle_valid !== 1'b1 || bus.slot_data !== {16'h0, 8'hA0 + 8'(i)} ||
          bus.slot_valid !== 3'b001) begin
        nFails++;
        $display("FAIL single_%0d got pr=%b bv=%b data=%h sv=%b exp pr=1 bv=1 data=0000%h sv=001",
                 i, obsPr, bus.bundle_valid, bus.slot_data, bus.slot_valid, 8'hA0 + 8'(i));
      end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    cycle(1, 8'h01, 2'd2, 0, 0);
    cycle(1, 8'h02, 2'd2, 0, 0);
    cycle(1, 8'h03, 2'd2, 0, 0);
    cycle(1, 8'h04, 2'd2, 0, 0);
    nChecks++;
    if (obsPr !== 1'b1 || bus.bundle_valid !== 1'b1 || bus.slot_data !== 24'h000201 || bus.count !== 2'd2) begin
      nFails++;
      $display("FAIL bp_hold got pr=%b bv=%b data=%h cnt=%0d exp pr=1 bv=1 data=000201 cnt=2",
               obsPr, bus.bundle_valid, bus.slot_data, bus.count);
    end
    cycle(1, 8'h99, 2'd2, 0, 0);
    nChecks++;
    if (obsPr !== 1'b0 || bus.slot_data !== 24'h000201 || bus.slot_valid !== 3'b011 || bus.count !== 2'd2) begin
      nFails++;
      $display("FAIL bp_full got pr=%b data=%h sv=%b cnt=%0d exp pr=0 data=000201 sv=011 cnt=2",
               obsPr, bus.slot_data, bus.slot_valid, bus.count);
    end
    idle(1);
    nChecks++;
    if (obsPr !== 1'b0 || bus.bundle_valid !== 1'b1 || bus.slot_data !== 24'h000403 || bus.count !== 2'd0) begin
      nFails++;
      $display("FAIL bp_release got pr=%b bv=%b data=%h cnt=%0d exp pr=0 bv=1 data=000403 cnt=0",
               obsPr, bus.bundle_valid, bus.slot_data, bus.count);
    end
    idle(1);
    nChecks++;
    if (obsPr !== 1'b1 || bus.bundle_valid !== 1'b0) begin
      nFails++; $display("FAIL bp_drain got pr=%b bv=%b exp pr=1 bv=0", obsPr, bus.bundle_valid);
    end
  endtask

  task automatic test_flush();
    cycle(1, 8'h55, 2'd3, 0, 1);
    cycle(1, 8'h66, 2'd3, 0, 1);
    cycle(1, 8'hAA, 2'd3, 1, 1);
    nChecks++;
    if (obsPr !== 1'b0 || bus.count !== 2'd0 || bus.bundle_valid !== 1'b0) begin
      nFails++;
      $display("FAIL flush got pr=%b cnt=%0d bv=%b exp pr=0 cnt=0 bv=0", obsPr, bus.count, bus.bundle_valid);
    end
    cycle(1, 8'h77, 2'd2, 0, 1);
    cycle(1, 8'h88, 2'd2, 0, 1);
    nChecks++;
    if (bus.bundle_valid !== 1'b1 || bus.slot_data !== 24'h008877 || bus.slot_valid !== 3'b011) begin
      nFails++;
      $display("FAIL flush_next got bv=%b data=%h sv=%b exp bv=1 data=008877 sv=011",
               bus.bundle_valid, bus.slot_data, bus.slot_valid);
    end
    idle(1);
  endtask

  task automatic test_err_need();
    for (int b = 0; b < 2; b++) begin
      cycle(1, 8'hC1, 2'd0, 0, 1);
      nChecks++;
      if (bus.err_need !== 1'b1 || bus.count !== 2'd1) begin
        nFails++; $display("FAIL err_pulse_%0d got err=%b cnt=%0d exp err=1 cnt=1", b, bus.err_need, bus.count);
      end
      cycle(1, 8'hC2, 2'd2, 0, 1);
      nChecks++;
      if (bus.err_need !== 1'b0 || bus.count !== 2'd2) begin
        nFails++; $display("FAIL err_clear_%0d got err=%b cnt=%0d exp err=0 cnt=2", b, bus.err_need, bus.count);
      end
      cycle(1, 8'hC3, 2'd1, 0, 1);
      nChecks++;
      if (bus.bundle_valid !== 1'b1 || bus.slot_valid !== 3'b111 || bus.slot_data !== 24'hC3C2C1) begin
        nFails++;
        $display("FAIL err_bundle_%0d got bv=%b sv=%b data=%h exp bv=1 sv=111 data=c3c2c1",
                 b, bus.bundle_valid, bus.slot_valid, bus.slot_data);
      end
    end
    cycle(1, 8'hD0, 2'd3, 0, 1);
    nChecks++;
    if (bus.err_need !== 1'b0) begin nFails++; $display("FAIL err_valid_need got err=%b exp 0", bus.err_need); end
    cycle(1, 8'hD1, 2'd0, 1, 1);
    idle(1);
  endtask

  task automatic test_async_reset();
    cycle(1, 8'hE1, 2'd1, 0, 0);
    cycle(1, 8'hE2, 2'd3, 0, 0);
    cycle(1, 8'hE3, 2'd3, 0, 0);
    nChecks++;
    if (bus.count !== 2'd2 || bus.bundle_valid !== 1'b1) begin
      nFails++; $display("FAIL arst_setup got cnt=%0d bv=%b exp cnt=2 bv=1", bus.count, bus.bundle_valid);
    end
    bus.put_valid = 0;
    #2 reset = 1'b1;
    #1;
    nChecks++;
    if ({bus.put_ready, bus.bundle_valid, bus.slot_valid, bus.count, bus.err_need, bus.slot_data} !== '0) begin
      nFails++;
      $display("FAIL arst_immediate got pr=%b bv=%b sv=%b cnt=%0d data=%h exp all 0",
               bus.put_ready, bus.bundle_valid, bus.slot_valid, bus.count, bus.slot_data);
    end
    @(posedge clk); #1;
    nChecks++;
    if (bus.put_ready !== 1'b0) begin nFails++; $display("FAIL arst_held got pr=%b exp 0", bus.put_ready); end
    #2 reset = 1'b0;
    #1;
    nChecks++;
    if (bus.put_ready !== 1'b1) begin nFails++; $display("FAIL arst_release got pr=%b exp 1", bus.put_ready); end
    model_reset();
    @(posedge clk); #1;
    idle(1);
    nChecks++;
    if (bus.bundle_valid !== 1'b0 || bus.count !== 2'd0) begin
      nFails++; $display("FAIL arst_no_bundle got bv=%b cnt=%0d exp bv=0 cnt=0", bus.bundle_valid, bus.count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      nChecks++;
      if (obsPr !== expPr || bus.bundle_valid !== outValid || bus.count !== CW'(fillQ.size()) ||
          bus.err_need !== expErr || (outValid && (bus.slot_data !== exp_data() || bus.slot_valid !== exp_mask()))) begin
        nFails++;
        $display("FAIL rand_%0d got pr=%b bv=%b cnt=%0d err=%b data=%h sv=%b exp pr=%b bv=%b cnt=%0d err=%b data=%h sv=%b",
                 c, obsPr, bus.bundle_valid, bus.count, bus.err_need, bus.slot_data, bus.slot_valid,
                 expPr, outValid, fillQ.size(), expErr, exp_data(), exp_mask());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_back_to_back();
    test_flush();
    test_err_need();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
